// File: rtl/pulp_clock_gate_ctrl_pkg.sv
// Shared types and the timer-width helper for the clock-gate controller.
// Pure declarations: no latency, no flow control.
package pulp_clock_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        CG_OFF  = 2'd0,
        CG_WAKE = 2'd1,
        CG_ON   = 2'd2,
        CG_HOLD = 2'd3
    } cg_state_e;

    // Never returns 0 so the timer stays a legal vector in the zero-delay build.
    function automatic int cnt_width(input int wake, input int idle);
        int m;
        m = (wake > idle) ? wake : idle;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pulp_cgc_timer.sv
// Loadable down-counter shared by the wake and hold phases; load wins over dec.
// One-cycle update latency, saturates at zero, no backpressure.
module pulp_cgc_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulp_clock_gate_ctrl.sv
// Shared clock-domain gate: ungates on request, grants after WAKE_CYCLES, holds IDLE_CYCLES after release.
// Grant latency WAKE_CYCLES+1 from off, 1 from hold, 0 while on; requesters are never stalled, only un-acked.
module pulp_clock_gate_ctrl
    import pulp_clock_gate_ctrl_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WAKE_CYCLES = 4,
    parameter int IDLE_CYCLES = 8,
    parameter int CNT_W       = cnt_width(WAKE_CYCLES, IDLE_CYCLES)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] ack_o,
    input  logic               test_en_i,
    output logic               clk_en_o,
    output logic [1:0]         state_o
);

    localparam logic [CNT_W-1:0] WAKE_LOAD = (WAKE_CYCLES > 0) ? CNT_W'(WAKE_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] IDLE_LOAD = (IDLE_CYCLES > 0) ? CNT_W'(IDLE_CYCLES - 1) : '0;

    cg_state_e        state_q, state_d;
    logic             any_req;
    logic             tmr_load, tmr_dec, tmr_zero;
    logic [CNT_W-1:0] tmr_value;

    assign any_req = |req_i;

    always_comb begin
        state_d   = state_q;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        tmr_value = '0;
        unique case (state_q)
            CG_OFF: begin
                if (any_req) begin
                    if (WAKE_CYCLES > 0) begin
                        state_d   = CG_WAKE;
                        tmr_load  = 1'b1;
                        tmr_value = WAKE_LOAD;
                    end else begin
                        state_d = CG_ON;
                    end
                end
            end
            // A request drop here is deliberately ignored: wake always completes.
            CG_WAKE: begin
                if (tmr_zero) state_d = CG_ON;
                else          tmr_dec = 1'b1;
            end
            CG_ON: begin
                if (!any_req) begin
                    if (IDLE_CYCLES > 0) begin
                        state_d   = CG_HOLD;
                        tmr_load  = 1'b1;
                        tmr_value = IDLE_LOAD;
                    end else begin
                        state_d = CG_OFF;
                    end
                end
            end
            CG_HOLD: begin
                if (any_req)       state_d = CG_ON;
                else if (tmr_zero) state_d = CG_OFF;
                else               tmr_dec = 1'b1;
            end
            default: state_d = CG_OFF;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= CG_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    pulp_cgc_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (tmr_load),
        .value_i (tmr_value),
        .dec_i   (tmr_dec),
        .zero_o  (tmr_zero)
    );

    assign clk_en_o = (state_q != CG_OFF) | test_en_i;
    assign ack_o    = req_i & {NUM_REQ{state_q == CG_ON}};
    assign state_o  = state_q;

endmodule

// File: tb/tb_pulp_clock_gate_ctrl.sv
// Directed bench for the clock-gate controller: default build (W=4,I=8) and a zero-delay build.
module tb_pulp_clock_gate_ctrl;

    localparam logic [1:0] S_OFF  = 2'd0;
    localparam logic [1:0] S_WAKE = 2'd1;
    localparam logic [1:0] S_ON   = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req0, req1, ack0, ack1;
    logic       ten0, ten1, en0, en1;
    logic [1:0] st0, st1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        int         dut;
        logic [1:0] st;
        logic       en;
        logic [3:0] ack;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pulp_clock_gate_ctrl #(
        .NUM_REQ(4), .WAKE_CYCLES(4), .IDLE_CYCLES(8)
    ) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req0), .ack_o(ack0),
        .test_en_i(ten0), .clk_en_o(en0), .state_o(st0)
    );

    pulp_clock_gate_ctrl #(
        .NUM_REQ(4), .WAKE_CYCLES(0), .IDLE_CYCLES(0)
    ) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req1), .ack_o(ack1),
        .test_en_i(ten1), .clk_en_o(en1), .state_o(st1)
    );

    task automatic push(input string tag, input int dut, input logic [1:0] st,
                        input logic en, input logic [3:0] ack);
        exp_t e;
        e.tag = tag; e.dut = dut; e.st = st; e.en = en; e.ack = ack;
        sb.push_back(e);
    endtask

    task automatic pop_chk();
        exp_t       e;
        logic [1:0] st;
        logic       en;
        logic [3:0] ack;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty got no expectation exp one queued");
            return;
        end
        e = sb.pop_front();
        if (e.dut == 0) begin st = st0; en = en0; ack = ack0; end
        else            begin st = st1; en = en1; ack = ack1; end
        checks++;
        assert (st === e.st) else begin
            errors++;
            $error("FAIL %s state_o got %0d exp %0d", e.tag, st, e.st);
        end
        checks++;
        assert (en === e.en) else begin
            errors++;
            $error("FAIL %s clk_en_o got %b exp %b", e.tag, en, e.en);
        end
        checks++;
        assert (ack === e.ack) else begin
            errors++;
            $error("FAIL %s ack_o got %b exp %b", e.tag, ack, e.ack);
        end
    endtask

    // Combinational check in the current cycle, no clock edge.
    task automatic now_chk();
        #1;
        pop_chk();
    endtask

    // Advance n edges, checking one queued expectation after each.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            pop_chk();
        end
    endtask

    initial begin
        rst_n = 1'b0; req0 = '0; req1 = '0; ten0 = 1'b0; ten1 = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        push("reset0", 0, S_OFF, 1'b0, 4'b0000); now_chk();
        push("reset1", 1, S_OFF, 1'b0, 4'b0000); now_chk();

        // Cold wake
        req0 = 4'b0001;
        for (int i = 0; i < 4; i++) push("cold_wake", 0, S_WAKE, 1'b1, 4'b0000);
        push("cold_ack", 0, S_ON, 1'b1, 4'b0001);
        run(5);

        // Multiple requesters, combinational acks
        req0 = 4'b0011; push("multi_a", 0, S_ON, 1'b1, 4'b0011); now_chk();
        req0 = 4'b1011; push("multi_b", 0, S_ON, 1'b1, 4'b1011); now_chk();
        req0 = 4'b1000; push("multi_c", 0, S_ON, 1'b1, 4'b1000); now_chk();
        push("multi_keep", 0, S_ON, 1'b1, 4'b1000);
        push("multi_keep", 0, S_ON, 1'b1, 4'b1000);
        run(2);

        // Release and hysteresis
        req0 = 4'b0000; push("rel_now", 0, S_ON, 1'b1, 4'b0000); now_chk();
        for (int i = 0; i < 8; i++) push("rel_hold", 0, S_HOLD, 1'b1, 4'b0000);
        push("rel_off", 0, S_OFF, 1'b0, 4'b0000);
        run(9);

        // Re-request on 5th HOLD cycle
        req0 = 4'b0100;
        for (int i = 0; i < 4; i++) push("rr_wake", 0, S_WAKE, 1'b1, 4'b0000);
        push("rr_on", 0, S_ON, 1'b1, 4'b0100);
        run(5);
        req0 = 4'b0000;
        for (int i = 0; i < 5; i++) push("rr_hold", 0, S_HOLD, 1'b1, 4'b0000);
        run(5);
        req0 = 4'b0100; push("rr_hold_noack", 0, S_HOLD, 1'b1, 4'b0000); now_chk();
        push("rr_reon", 0, S_ON, 1'b1, 4'b0100);
        run(1);

        // Re-request exactly when the timer hits zero
        req0 = 4'b0000;
        for (int i = 0; i < 8; i++) push("tz_hold", 0, S_HOLD, 1'b1, 4'b0000);
        run(8);
        req0 = 4'b0001; push("tz_last", 0, S_HOLD, 1'b1, 4'b0000); now_chk();
        push("tz_on", 0, S_ON, 1'b1, 4'b0001);
        run(1);

        // Back to OFF, then a one-cycle pulse
        req0 = 4'b0000;
        for (int i = 0; i < 8; i++) push("p_pre_hold", 0, S_HOLD, 1'b1, 4'b0000);
        push("p_pre_off", 0, S_OFF, 1'b0, 4'b0000);
        run(9);
        req0 = 4'b0001;
        push("pulse_wake", 0, S_WAKE, 1'b1, 4'b0000);
        run(1);
        req0 = 4'b0000;
        for (int i = 0; i < 3; i++) push("pulse_wake", 0, S_WAKE, 1'b1, 4'b0000);
        push("pulse_on", 0, S_ON, 1'b1, 4'b0000);
        for (int i = 0; i < 8; i++) push("pulse_hold", 0, S_HOLD, 1'b1, 4'b0000);
        push("pulse_off", 0, S_OFF, 1'b0, 4'b0000);
        run(13);

        // Reset during HOLD
        req0 = 4'b0001;
        for (int i = 0; i < 4; i++) push("rh_wake", 0, S_WAKE, 1'b1, 4'b0000);
        push("rh_on", 0, S_ON, 1'b1, 4'b0001);
        run(5);
        req0 = 4'b0000;
        for (int i = 0; i < 3; i++) push("rh_hold", 0, S_HOLD, 1'b1, 4'b0000);
        run(3);
        rst_n = 1'b0;
        push("rh_reset", 0, S_OFF, 1'b0, 4'b0000);
        run(1);
        rst_n = 1'b1;

        // DFT override on default build
        ten0 = 1'b1; push("dft0", 0, S_OFF, 1'b1, 4'b0000); now_chk();
        ten0 = 1'b0;

        // Zero-delay build
        req1 = 4'b0010; push("z_pre", 1, S_OFF, 1'b0, 4'b0000); now_chk();
        push("z_on", 1, S_ON, 1'b1, 4'b0010);
        run(1);
        req1 = 4'b0000; push("z_rel", 1, S_ON, 1'b1, 4'b0000); now_chk();
        push("z_off", 1, S_OFF, 1'b0, 4'b0000);
        run(1);
        ten1 = 1'b1; push("z_dft", 1, S_OFF, 1'b1, 4'b0000); now_chk();
        req1 = 4'b0001;
        push("z_dft_on", 1, S_ON, 1'b1, 4'b0001);
        run(1);
        req1 = 4'b0000;
        push("z_dft_off", 1, S_OFF, 1'b1, 4'b0000);
        run(1);
        ten1 = 1'b0; push("z_dft_clr", 1, S_OFF, 1'b0, 4'b0000); now_chk();

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_leftover got %0d entries exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulp_clock_gate_ctrl.md
Name: pulp_clock_gate_ctrl

Overview:
- Controls a shared gated clock domain for NUM_REQ requesters.
- Drives the enable of a downstream clock-gating cell. The gated clock then feeds the domain's clock buffer tree.
- Ungates the clock on demand and waits a programmable settle time before granting.
- Keeps the clock running for an idle hysteresis window after the last requester releases, then gates it off.

Parameters:
- NUM_REQ, 4, number of requesters (>=1).
- WAKE_CYCLES, 4, cycles between enabling the clock and granting (>=0).
- IDLE_CYCLES, 8, hysteresis cycles the clock stays on after the last release (>=0).
- CNT_W, $clog2(max(WAKE_CYCLES,IDLE_CYCLES)+1), shared timer width (derived; do not override).

Ports:
- clk_i  input  1  free-running clock.
- rst_ni  input  1  reset. Synchronous, active-low.
- req_i  input  NUM_REQ  per-requester clock request. Level; held while the clock is needed.
- ack_o  output  NUM_REQ  per-requester grant. Clock is running and stable.
- test_en_i  input  1  DFT override. Forces clk_en_o=1 and does not alter the FSM.
- clk_en_o  output  1  enable to the clock-gating cell.
- state_o  output  2  current FSM state, for status/debug.

Behaviour:
- Single clock, one always_ff. Reset is sampled on the rising clk_i edge when rst_ni=0.
- Reset values: state=OFF, timer=0. Outputs: ack_o=0, state_o=OFF. clk_en_o=test_en_i.
- States (2-bit encoding):
  - OFF=0
  - WAKE=1
  - ON=2
  - HOLD=3
- any_req = |req_i.
- OFF:
  - any_req and WAKE_CYCLES>0 -> WAKE, load timer=WAKE_CYCLES-1.
  - any_req and WAKE_CYCLES==0 -> ON.
  - Otherwise stay in OFF.
- WAKE:
  - timer==0 -> ON; else decrement timer.
  - No abort: a request drop during WAKE still completes WAKE, then ON, then HOLD.
- ON:
  - !any_req and IDLE_CYCLES>0 -> HOLD, load timer=IDLE_CYCLES-1.
  - !any_req and IDLE_CYCLES==0 -> OFF.
  - Otherwise stay in ON.
- HOLD:
  - any_req -> ON (clock is still running, no re-wake).
  - Else timer==0 -> OFF; else decrement timer.
  - any_req has priority over timer expiry in the same cycle.
- clk_en_o = (state_q != OFF) | test_en_i. It is high for every cycle in WAKE, ON and HOLD.
- ack_o[i] = req_i[i] & (state_q==ON). Combinational from the registered state. No acks in OFF, WAKE or HOLD.
- Latencies:
  - req rising, sampled at edge t: state WAKE from t+1, state ON and ack at t+1+WAKE_CYCLES.
  - Hence req->ack = WAKE_CYCLES+1 cycles from OFF, and 1 cycle from HOLD.
  - A requester arriving while ON is acked the same cycle.
- Release:
  - The last req falls while ON -> HOLD for IDLE_CYCLES cycles -> OFF.
  - clk_en_o drops IDLE_CYCLES+1 cycles after the first cycle with all req low.
- Requesters are not arbitrated. All concurrent requesters are granted simultaneously.
- Reset mid-operation (any state): next state OFF, timer 0, ack_o=0 immediately after the edge.
- Timer never wraps. It is loaded only on state entry and is not decremented below 0.
- test_en_i changes neither state nor ack_o.

Decomposition:
- Package pulp_clock_gate_ctrl_pkg:
  - typedef enum logic [1:0] cg_state_e {CG_OFF, CG_WAKE, CG_ON, CG_HOLD}.
  - Helper function cnt_width(wake, idle).
- One sub-module, pulp_cgc_timer: loadable down-counter (load_i, value_i, dec_i, zero_o). Shared by WAKE and HOLD.
- FSM and output logic stay in the top.

Test Plan:
- Cold wake (W=4, I=8): reset, then req_i=0001 at edge t.
  - clk_en_o=1 from t+1.
  - state_o=WAKE for t+1..t+4.
  - ack_o=0001 at t+5.
- Release and hysteresis: from ON, drop req_i to 0 at edge t.
  - HOLD for 8 cycles with clk_en_o=1 and ack_o=0.
  - state_o=OFF and clk_en_o=0 at t+9.
- Re-request in HOLD: drop all requests, then req_i=0100 on the 5th HOLD cycle.
  - state_o=ON and ack_o=0100 next cycle.
  - No WAKE entered.
  - Also assert req exactly when timer==0: the FSM must go to ON, not OFF.
- Multiple requesters: req_i=0011 in ON, then req_i=1011.
  - ack_o tracks req_i combinationally.
  - Dropping bits 0 and 1 keeps ON while bit 3 stays high.
- Mid-WAKE drop and reset:
  - Pulse req for 1 cycle from OFF: full WAKE (4 cycles), then ON for 1 cycle, then HOLD (8 cycles), then OFF. ack_o stays 0 throughout.
  - Separately, rst_ni=0 during HOLD: next cycle state_o=OFF and clk_en_o=0.
- Zero-parameter build (W=0, I=0) plus DFT:
  - req -> ack in 1 cycle; release -> OFF in 1 cycle.
  - test_en_i=1 in OFF gives clk_en_o=1 with state_o=OFF and ack_o=0.
